// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// a constant-evaluable ceil(log2) used to size the internal counters.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      STRETCH   = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } state_e;

   // Smallest r with 2**r >= value; callers pass max_count+1 to size a counter.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(value)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level, with a synchronous
// clear so the sequencer can discard stale lock history while it holds reset.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic i_clr,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (i_clr) r_sync <= '0;
      else       r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset manager: qualifies PLL lock, stretches reset, then releases domains in
// order with a stagger. Optional watchdog restart under RESET_SEQ_WDT_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned N_DOMAINS      = 3,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned LOCK_FILTER    = 4,
   parameter int unsigned STRETCH_CYCLES = 128,
   parameter int unsigned STAGGER        = 16,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned WDT_CYCLES     = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pll_lock,
   input  logic                 sw_rst_req,
   input  logic                 wdt_kick,
   output logic [N_DOMAINS-1:0] rst_out,
   output logic                 ready,
   output logic [CNT_W-1:0]     lock_loss_cnt,
   output logic                 wdt_fired
);

   localparam int unsigned FILT_W = clog2(LOCK_FILTER + 1);
   localparam int unsigned STR_W  = clog2(STRETCH_CYCLES + 1);
   localparam int unsigned STG_W  = clog2(STAGGER + 1);

   state_e               r_state, w_state_nxt;
   logic [FILT_W-1:0]    r_filt, w_filt_nxt;
   logic [STR_W-1:0]     r_str, w_str_nxt;
   logic [STG_W-1:0]     r_stg, w_stg_nxt;
   logic [N_DOMAINS-1:0] r_rst_out, w_rst_nxt, w_rst_shift;
   logic                 r_ready, w_ready_nxt;
   logic [CNT_W-1:0]     r_loss_cnt, w_loss_nxt;
   logic                 w_lock_s, w_sync_clr, w_wdt_fire;

   // Lock history is discarded while held in reset so qualification always starts fresh.
   assign w_sync_clr = rst | (r_state == HOLD);

   sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk  (clk),
      .i_clr(w_sync_clr),
      .i_d  (pll_lock),
      .o_q  (w_lock_s)
   );

   // Releasing shifts a zero in from bit 0, so domains can only clear in index order.
   assign w_rst_shift = r_rst_out << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= HOLD;
         r_filt     <= '0;
         r_str      <= '0;
         r_stg      <= '0;
         r_rst_out  <= '1;
         r_ready    <= 1'b0;
         r_loss_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_filt     <= w_filt_nxt;
         r_str      <= w_str_nxt;
         r_stg      <= w_stg_nxt;
         r_rst_out  <= w_rst_nxt;
         r_ready    <= w_ready_nxt;
         r_loss_cnt <= w_loss_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_filt_nxt  = r_filt;
      w_str_nxt   = r_str;
      w_stg_nxt   = r_stg;
      w_rst_nxt   = r_rst_out;
      w_ready_nxt = r_ready;
      w_loss_nxt  = r_loss_cnt;

      case (r_state)
         HOLD: begin
            w_state_nxt = WAIT_LOCK;
            w_filt_nxt  = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
         end
         WAIT_LOCK: begin
            if (!w_lock_s) begin
               w_filt_nxt = '0;
            end else if (r_filt == FILT_W'(LOCK_FILTER)) begin
               w_state_nxt = STRETCH;
               w_str_nxt   = '0;
            end else begin
               w_filt_nxt = r_filt + FILT_W'(1);
            end
         end
         STRETCH: begin
            if (r_str == STR_W'(STRETCH_CYCLES - 1)) begin
               w_rst_nxt = w_rst_shift;
               w_stg_nxt = '0;
               if (w_rst_shift == '0) begin
                  w_state_nxt = RUN;
                  w_ready_nxt = 1'b1;
               end else begin
                  w_state_nxt = RELEASE;
               end
            end else begin
               w_str_nxt = r_str + STR_W'(1);
            end
         end
         RELEASE: begin
            if (r_stg == STG_W'(STAGGER - 1)) begin
               w_rst_nxt = w_rst_shift;
               w_stg_nxt = '0;
               if (w_rst_shift == '0) begin
                  w_state_nxt = RUN;
                  w_ready_nxt = 1'b1;
               end
            end else begin
               w_stg_nxt = r_stg + STG_W'(1);
            end
         end
         RUN: begin
            w_state_nxt = RUN;
         end
         default: begin
            w_state_nxt = HOLD;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
         end
      endcase

      // Restart sources once lock has been qualified; lock loss has priority.
      if (r_state inside {STRETCH, RELEASE, RUN}) begin
         if (!w_lock_s) begin
            w_state_nxt = WAIT_LOCK;
            w_filt_nxt  = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
            if (r_loss_cnt != '1) w_loss_nxt = r_loss_cnt + CNT_W'(1);
         end else if (sw_rst_req || w_wdt_fire) begin
            w_state_nxt = STRETCH;
            w_str_nxt   = '0;
            w_rst_nxt   = '1;
            w_ready_nxt = 1'b0;
         end
      end
   end

`ifdef RESET_SEQ_WDT_EN
   localparam int unsigned WDT_W = clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] r_wdt_cnt, w_wdt_cnt_nxt;
   logic             r_wdt_fired;

   assign w_wdt_fire = (r_state == RUN) && w_lock_s && !wdt_kick &&
                       (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));
   assign w_wdt_cnt_nxt = ((r_state == RUN) && (w_state_nxt == RUN) && !wdt_kick) ?
                          r_wdt_cnt + WDT_W'(1) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdt_cnt   <= '0;
         r_wdt_fired <= 1'b0;
      end else begin
         r_wdt_cnt   <= w_wdt_cnt_nxt;
         r_wdt_fired <= r_wdt_fired | w_wdt_fire;
      end
   end

   assign wdt_fired = r_wdt_fired;
`else
   logic w_unused;
   assign w_unused   = ^{wdt_kick, 32'(WDT_CYCLES)};
   assign w_wdt_fire = 1'b0;
   assign wdt_fired  = 1'b0;
`endif

   assign rst_out       = r_rst_out;
   assign ready         = r_ready;
   assign lock_loss_cnt = r_loss_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with small timing parameters; the
// watchdog scenario is exercised when RESET_SEQ_WDT_EN is defined.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_lock = 1'b0;
   logic       sw_rst_req = 1'b0;
   logic       wdt_kick = 1'b0;
   logic [2:0] rst_out;
   logic       ready;
   logic [7:0] lock_loss_cnt;
   logic       wdt_fired;

   int n_checks = 0;
   int n_fail   = 0;

   reset_sequencer #(
      .N_DOMAINS     (3),
      .SYNC_STAGES   (2),
      .LOCK_FILTER   (4),
      .STRETCH_CYCLES(8),
      .STAGGER       (4),
      .CNT_W         (8),
      .WDT_CYCLES    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_lock     (pll_lock),
      .sw_rst_req   (sw_rst_req),
      .wdt_kick     (wdt_kick),
      .rst_out      (rst_out),
      .ready        (ready),
      .lock_loss_cnt(lock_loss_cnt),
      .wdt_fired    (wdt_fired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; afterwards outputs reflect the last edge.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ticks(3);
      rst = 1'b0;
   endtask

   initial begin
      // Power-up with stable lock: rst_out[0] at E15, [1] at E19, [2]+ready at E23
      pll_lock = 1'b1;
      do_reset();
      check("rst_rst_out", 32'(rst_out), 32'd7);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_cnt", 32'(lock_loss_cnt), 32'd0);
      check("rst_wdt", 32'(wdt_fired), 32'd0);
      ticks(15);
      check("pu_e14", 32'(rst_out), 32'd7);
      ticks(1);
      check("pu_e15", 32'(rst_out), 32'd6);
      ticks(3);
      check("pu_e18", 32'(rst_out), 32'd6);
      ticks(1);
      check("pu_e19", 32'(rst_out), 32'd4);
      ticks(3);
      check("pu_e22_ready", 32'(ready), 32'd0);
      ticks(1);
      check("pu_e23", 32'(rst_out), 32'd0);
      check("pu_e23_ready", 32'(ready), 32'd1);
      check("pu_cnt", 32'(lock_loss_cnt), 32'd0);

      // Lock drop in RUN: reset reasserts on the third edge, counter +1
      pll_lock = 1'b0;
      ticks(2);
      check("drop_d1", 32'(rst_out), 32'd0);
      ticks(1);
      check("drop_d2", 32'(rst_out), 32'd7);
      check("drop_ready", 32'(ready), 32'd0);
      check("drop_cnt", 32'(lock_loss_cnt), 32'd1);

      // Relock: rst_out[0] releases 14 edges after lock returns
      pll_lock = 1'b1;
      ticks(14);
      check("relock_r13", 32'(rst_out), 32'd7);
      ticks(1);
      check("relock_r14", 32'(rst_out), 32'd6);

      // Software request during RELEASE: all ones next edge, rst_out[0] 8 edges later
      sw_rst_req = 1'b1;
      ticks(1);
      sw_rst_req = 1'b0;
      check("sw_s0", 32'(rst_out), 32'd7);
      check("sw_cnt", 32'(lock_loss_cnt), 32'd1);
      ticks(7);
      check("sw_s7", 32'(rst_out), 32'd7);
      ticks(1);
      check("sw_s8", 32'(rst_out), 32'd6);
      ticks(8);
      check("sw_ready", 32'(ready), 32'd1);
      check("sw_rst_out", 32'(rst_out), 32'd0);

      // Lock loss and sw request on the same edge: lock loss wins (WAIT_LOCK path)
      pll_lock = 1'b0;
      ticks(1);
      pll_lock = 1'b1;
      ticks(1);
      sw_rst_req = 1'b1;
      ticks(1);
      sw_rst_req = 1'b0;
      check("both_rst_out", 32'(rst_out), 32'd7);
      check("both_cnt", 32'(lock_loss_cnt), 32'd2);
      ticks(12);
      check("both_d14", 32'(rst_out), 32'd7);
      ticks(1);
      check("both_d15", 32'(rst_out), 32'd6);

      // rst in the middle of STRETCH returns everything to reset values
      sw_rst_req = 1'b1;
      ticks(1);
      sw_rst_req = 1'b0;
      ticks(3);
      rst = 1'b1;
      ticks(1);
      check("midrst_rst_out", 32'(rst_out), 32'd7);
      check("midrst_ready", 32'(ready), 32'd0);
      check("midrst_cnt", 32'(lock_loss_cnt), 32'd0);
      check("midrst_wdt", 32'(wdt_fired), 32'd0);
      rst = 1'b0;

      // Lock glitching low one cycle in three never qualifies
      for (int i = 0; i < 30; i++) begin
         pll_lock = (i % 3 != 2);
         ticks(1);
      end
      check("glitch_rst_out", 32'(rst_out), 32'd7);
      check("glitch_ready", 32'(ready), 32'd0);

      // Stable lock again, sw request while still in WAIT_LOCK has no effect
      pll_lock = 1'b1;
      ticks(3);
      sw_rst_req = 1'b1;
      ticks(1);
      sw_rst_req = 1'b0;
      ticks(10);
      check("wl_sw_g13", 32'(rst_out), 32'd7);
      ticks(1);
      check("wl_sw_g14", 32'(rst_out), 32'd6);
      ticks(8);
      check("wl_sw_ready", 32'(ready), 32'd1);

`ifndef RESET_SEQ_WDT_EN
      // Without the watchdog an unkicked RUN stays up
      ticks(40);
      check("nowdt_ready", 32'(ready), 32'd1);
      check("nowdt_fired", 32'(wdt_fired), 32'd0);
`endif

      // Repeated lock loss in STRETCH: counter counts and saturates at 255
      do_reset();
      for (int i = 0; i < 300; i++) begin
         pll_lock = 1'b1;
         ticks(10);
         pll_lock = 1'b0;
         ticks(4);
         if (i == 9) check("loss_cnt_10", 32'(lock_loss_cnt), 32'd10);
      end
      check("loss_cnt_sat", 32'(lock_loss_cnt), 32'd255);
      check("loss_rst_out", 32'(rst_out), 32'd7);

`ifdef RESET_SEQ_WDT_EN
      // Watchdog: kicks every 20 cycles keep RUN; stopping fires 32 cycles after last kick
      pll_lock = 1'b1;
      do_reset();
      ticks(24);
      check("wdt_run", 32'(ready), 32'd1);
      for (int k = 0; k < 3; k++) begin
         ticks(19);
         wdt_kick = 1'b1;
         ticks(1);
         wdt_kick = 1'b0;
      end
      check("wdt_kicked_ready", 32'(ready), 32'd1);
      check("wdt_kicked_fired", 32'(wdt_fired), 32'd0);
      ticks(31);
      check("wdt_k31", 32'(rst_out), 32'd0);
      ticks(1);
      check("wdt_k32_rst_out", 32'(rst_out), 32'd7);
      check("wdt_k32_fired", 32'(wdt_fired), 32'd1);
      check("wdt_k32_ready", 32'(ready), 32'd0);
      ticks(7);
      check("wdt_k39", 32'(rst_out), 32'd7);
      ticks(1);
      check("wdt_k40", 32'(rst_out), 32'd6);
      ticks(8);
      check("wdt_rerun_ready", 32'(ready), 32'd1);
      check("wdt_sticky", 32'(wdt_fired), 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
